// File: rtl/cpu_ctrl_pkg.sv
// Control-unit types shared by the sequencer and its opcode decoder.
// The datapath ALU imports the same opcode constants so both agree on IR[31:27].
package cpu_ctrl_pkg;

    localparam int OPW_DEF = 5;
    localparam int IRW_DEF = 32;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'd3;
    localparam opcode_t OP_SUB  = 5'd4;
    localparam opcode_t OP_AND  = 5'd5;
    localparam opcode_t OP_OR   = 5'd6;
    localparam opcode_t OP_SHR  = 5'd7;
    localparam opcode_t OP_SHRA = 5'd8;
    localparam opcode_t OP_SHL  = 5'd9;
    localparam opcode_t OP_ROR  = 5'd10;
    localparam opcode_t OP_ROL  = 5'd11;
    localparam opcode_t OP_MUL  = 5'd15;
    localparam opcode_t OP_DIV  = 5'd16;
    localparam opcode_t OP_NEG  = 5'd17;
    localparam opcode_t OP_NOT  = 5'd18;
    localparam opcode_t OP_NOP  = 5'd26;
    localparam opcode_t OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8
    } state_e;

    typedef struct packed {
        logic valid;
        logic two_operand;
        logic wide_result;
        logic is_halt;
        logic is_nop;
    } opdec_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_low_out;
        logic z_high_out;
        logic lo_in;
        logic hi_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } strobe_t;

    function automatic logic is_valid_op(opcode_t op);
        return op inside {[OP_ADD:OP_ROL], OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_NOP, OP_HALT};
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath strobe bundle; master is the control unit, slave the datapath side.
interface control_sequencer_if
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = OPW_DEF,
    parameter int IRW = IRW_DEF
);
    logic           run;
    logic           mem_ready;
    logic [IRW-1:0] ir_data;

    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowout, ZHighout, LOin, HIin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [OPW-1:0] alu_op;
    logic busy, halted, illegal_op;

    modport master (
        input  run, mem_ready, ir_data,
        output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
        output Zlowout, ZHighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout,
        output alu_op, busy, halted, illegal_op
    );

    modport slave (
        output run, mem_ready, ir_data,
        input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  Zlowout, ZHighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout,
        input  alu_op, busy, halted, illegal_op
    );
endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier used by the sequencer's decode (T3) and ALU (T4/T5) steps.
module ctrl_opdecode
    import cpu_ctrl_pkg::*;
(
    input  opcode_t opcode,
    output opdec_t  dec
);
    always_comb begin
        dec             = '0;
        dec.valid       = is_valid_op(opcode);
        dec.two_operand = (opcode == OP_NEG) || (opcode == OP_NOT);
        dec.wide_result = (opcode == OP_MUL) || (opcode == OP_DIV);
        dec.is_halt     = (opcode == OP_HALT);
        dec.is_nop      = (opcode == OP_NOP);
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2), decode (T3), ALU/register write-back (T4-T6).
// Strobes decode from the state register; only T1's PCin also waits on mem_ready.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW      = OPW_DEF,
    parameter int IRW      = IRW_DEF,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master bus
);
    state_e         state_q, state_d, done_state;
    logic           run_q, run_d;
    logic           illegal_q, illegal_d;
    logic [OPW-1:0] opcode;
    logic           ir_unused;
    opdec_t         dec;
    strobe_t        st;
    logic [OPW-1:0] alu_op;
    logic           mem_go;

    assign opcode    = bus.ir_data[IRW-1 -: OPW];
    assign ir_unused = ^bus.ir_data[IRW-OPW-1:0];
    assign mem_go    = !MEM_WAIT || bus.mem_ready;

    ctrl_opdecode u_dec (
        .opcode (opcode),
        .dec    (dec)
    );

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        run_d      = bus.run;
        // A finished instruction only loops back to fetch while run is still high.
        done_state = bus.run ? S_T0 : S_IDLE;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     if (mem_go) state_d = S_T2;
            S_T2:     state_d = S_T3;
            S_T3: begin
                if (dec.is_halt) begin
                    state_d = S_HALTED;
                end else if (dec.is_nop) begin
                    state_d = done_state;
                end else if (!dec.valid) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALTED;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4:     state_d = S_T5;
            S_T5:     state_d = dec.wide_result ? S_T6 : done_state;
            S_T6:     state_d = done_state;
            S_HALTED: if (bus.run && !run_q) state_d = S_T0;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        st     = '0;
        alu_op = '0;
        case (state_q)
            S_T0: begin
                st.pc_out = 1'b1;
                st.mar_in = 1'b1;
                st.inc_pc = 1'b1;
                st.z_in   = 1'b1;
            end
            S_T1: begin
                // Read/MDRin stay up for the whole wait; PC only updates once data arrives.
                st.z_low_out = 1'b1;
                st.read      = 1'b1;
                st.mdr_in    = 1'b1;
                st.pc_in     = mem_go;
            end
            S_T2: begin
                st.mdr_out = 1'b1;
                st.ir_in   = 1'b1;
            end
            S_T3: begin
                if (dec.valid && !dec.is_halt && !dec.is_nop) begin
                    st.grb   = 1'b1;
                    st.r_out = 1'b1;
                    st.y_in  = 1'b1;
                end
            end
            S_T4: begin
                alu_op  = opcode;
                st.z_in = 1'b1;
                if (!dec.two_operand) begin
                    st.grc   = 1'b1;
                    st.r_out = 1'b1;
                end
            end
            S_T5: begin
                alu_op       = opcode;
                st.z_low_out = 1'b1;
                if (dec.wide_result) begin
                    st.lo_in = 1'b1;
                end else begin
                    st.gra  = 1'b1;
                    st.r_in = 1'b1;
                end
            end
            S_T6: begin
                st.z_high_out = 1'b1;
                st.hi_in      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCout      = st.pc_out;
    assign bus.MARin      = st.mar_in;
    assign bus.IncPC      = st.inc_pc;
    assign bus.Zin        = st.z_in;
    assign bus.PCin       = st.pc_in;
    assign bus.Read       = st.read;
    assign bus.MDRin      = st.mdr_in;
    assign bus.MDRout     = st.mdr_out;
    assign bus.IRin       = st.ir_in;
    assign bus.Yin        = st.y_in;
    assign bus.Zlowout    = st.z_low_out;
    assign bus.ZHighout   = st.z_high_out;
    assign bus.LOin       = st.lo_in;
    assign bus.HIin       = st.hi_in;
    assign bus.Gra        = st.gra;
    assign bus.Grb        = st.grb;
    assign bus.Grc        = st.grc;
    assign bus.Rin        = st.r_in;
    assign bus.Rout       = st.r_out;
    assign bus.alu_op     = alu_op;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign bus.halted     = (state_q == S_HALTED);
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction step model checked every cycle, plus directed traces.
module tb_control_sequencer;
    localparam bit MEM_WAIT = 1'b1;
    localparam int NB = 22;
    typedef logic [NB-1:0] vec_t;
    localparam int B_PCOUT = 21, B_MARIN = 20, B_INCPC = 19, B_ZIN = 18, B_PCIN = 17, B_READ = 16;
    localparam int B_MDRIN = 15, B_MDROUT = 14, B_IRIN = 13, B_YIN = 12, B_ZLO = 11, B_ZHI = 10;
    localparam int B_LOIN = 9, B_HIIN = 8, B_GRA = 7, B_GRB = 6, B_GRC = 5, B_RIN = 4, B_ROUT = 3;
    localparam int B_BUSY = 2, B_HALTED = 1, B_ILL = 0;

    localparam logic [31:0] I_AND  = 32'h2A2B8000;
    localparam logic [31:0] I_MUL  = {5'd15, 27'h0123456};
    localparam logic [31:0] I_BAD  = {5'h1E, 27'h0};
    localparam logic [31:0] I_NOP  = {5'd26, 27'h0};
    localparam logic [31:0] I_HALT = {5'd27, 27'h0};

    typedef enum int {C_ALU, C_TWO, C_WIDE, C_NOP, C_HALT, C_BAD} cls_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic mem_ready = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [31:0] next_instr = 32'h0;
    bit   cmp_en = 1'b0;
    bit   rand_mode = 1'b0;
    int   mem_lat = 0;
    int   rd_age = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    control_sequencer_if #(.OPW(5), .IRW(32)) bus ();
    control_sequencer #(.OPW(5), .IRW(32), .MEM_WAIT(MEM_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.run       = run;
    assign bus.mem_ready = mem_ready;
    assign bus.ir_data   = ir;

    vec_t dut_v;
    assign dut_v = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.PCin, bus.Read, bus.MDRin,
                    bus.MDRout, bus.IRin, bus.Yin, bus.Zlowout, bus.ZHighout, bus.LOin, bus.HIin,
                    bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.busy, bus.halted, bus.illegal_op};

    // Datapath stand-in: IR latches the fetched word when IRin is strobed.
    always @(posedge clk) if (bus.IRin) ir <= next_instr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cls_e op_class(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return C_ALU;
        if (op == 5'd17 || op == 5'd18) return C_TWO;
        if (op == 5'd15 || op == 5'd16) return C_WIDE;
        if (op == 5'd26) return C_NOP;
        if (op == 5'd27) return C_HALT;
        return C_BAD;
    endfunction

    function automatic int instr_len(input cls_e c);
        if (c == C_ALU || c == C_TWO) return 6;
        if (c == C_WIDE) return 7;
        return 4;
    endfunction

    // Model: mode 0 idle, 1 running at m_step within the current instruction, 2 halted.
    int   m_mode = 0;
    int   m_step = 0;
    bit   m_ill = 1'b0;
    bit   m_run_prev = 1'b0;
    cls_e mc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_step = 0; m_ill = 1'b0; m_run_prev = 1'b0;
        end else begin
            mc = op_class(ir[31:27]);
            if (m_mode == 0) begin
                if (run) begin m_mode = 1; m_step = 0; end
            end else if (m_mode == 2) begin
                if (run && !m_run_prev) begin m_mode = 1; m_step = 0; end
            end else begin
                if (m_step == 1 && MEM_WAIT && !mem_ready) begin
                    m_step = 1;
                end else if (m_step == 3 && (mc == C_HALT || mc == C_BAD)) begin
                    m_mode = 2;
                    if (mc == C_BAD) m_ill = 1'b1;
                end else if (m_step + 1 == instr_len(mc)) begin
                    m_step = 0;
                    if (!run) m_mode = 0;
                end else begin
                    m_step++;
                end
            end
            m_run_prev = run;
        end
    end

    function automatic vec_t model_vec();
        vec_t v = '0;
        cls_e c = op_class(ir[31:27]);
        if (rst) return '0;
        v[B_ILL] = m_ill;
        v[B_HALTED] = (m_mode == 2);
        if (m_mode == 1) begin
            v[B_BUSY] = 1'b1;
            case (m_step)
                0: begin v[B_PCOUT] = 1; v[B_MARIN] = 1; v[B_INCPC] = 1; v[B_ZIN] = 1; end
                1: begin v[B_ZLO] = 1; v[B_READ] = 1; v[B_MDRIN] = 1; v[B_PCIN] = !MEM_WAIT || mem_ready; end
                2: begin v[B_MDROUT] = 1; v[B_IRIN] = 1; end
                3: if (c == C_ALU || c == C_TWO || c == C_WIDE) begin
                       v[B_GRB] = 1; v[B_ROUT] = 1; v[B_YIN] = 1;
                   end
                4: begin v[B_ZIN] = 1; if (c != C_TWO) begin v[B_GRC] = 1; v[B_ROUT] = 1; end end
                5: begin
                       v[B_ZLO] = 1;
                       if (c == C_WIDE) v[B_LOIN] = 1;
                       else begin v[B_GRA] = 1; v[B_RIN] = 1; end
                   end
                6: begin v[B_ZHI] = 1; v[B_HIIN] = 1; end
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic logic [4:0] model_op();
        if (!rst && m_mode == 1 && (m_step == 4 || m_step == 5)) return ir[31:27];
        return 5'd0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("strobes", 32'(dut_v), 32'(model_vec()));
            chk("alu_op", 32'(bus.alu_op), 32'(model_op()));
            chk("one_out", 32'($countones({bus.PCout, bus.MDRout, bus.Zlowout, bus.ZHighout, bus.Rout}) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.Read) rd_age++; else rd_age = 0;
        if (rand_mode) mem_ready = ($urandom_range(0, 2) != 0);
        else mem_ready = (rd_age > mem_lat);
        #1;
    endtask

    vec_t       tr [0:31];
    logic [4:0] tr_op [0:31];
    int         tr_n = 0;

    // Records one instruction from its T0 until the next T0, halt or idle.
    task automatic run_trace(input logic [31:0] instr);
        next_instr = instr;
        for (int k = 0; k < 30 && !dut_v[B_PCOUT]; k++) tick();
        chk("t0_reached", 32'(dut_v[B_PCOUT]), 32'd1);
        tr_n = 0;
        for (int i = 0; i < 30; i++) begin
            tr[tr_n] = dut_v;
            tr_op[tr_n] = bus.alu_op;
            tr_n++;
            tick();
            if (dut_v[B_PCOUT] || dut_v[B_HALTED] || !dut_v[B_BUSY]) break;
        end
    endtask

    function automatic int cnt(input int b);
        int n = 0;
        for (int i = 0; i < tr_n; i++) n += int'(tr[i][b]);
        return n;
    endfunction

    function automatic int first(input int b);
        for (int i = 0; i < tr_n; i++) if (tr[i][b]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] op;
        int k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3, 4: op = 5'($urandom_range(3, 11));
            5:             op = ($urandom_range(0, 1) != 0) ? 5'd17 : 5'd18;
            6:             op = ($urandom_range(0, 1) != 0) ? 5'd15 : 5'd16;
            7:             op = 5'd26;
            8:             op = 5'd27;
            default:       op = 5'($urandom_range(0, 31));
        endcase
        return {op, 27'($urandom)};
    endfunction

    initial begin
        #2 rst = 1'b1;
        #1 cmp_en = 1'b1;
        #1;
        chk("reset_outs", 32'(dut_v), 32'd0);
        chk("reset_aluop", 32'(bus.alu_op), 32'd0);
        tick();
        rst = 1'b0;
        run = 1'b1;

        // ALU op, no memory wait
        run_trace(I_AND);
        chk("alu_len", 32'(tr_n), 32'd6);
        chk("alu_gra", 32'(cnt(B_GRA)), 32'd1);
        chk("alu_rin_at", 32'(first(B_RIN)), 32'd5);
        chk("alu_gra_rin_t5", 32'(tr[5][B_GRA] & tr[5][B_RIN]), 32'd1);
        chk("alu_op_t3", 32'(tr_op[3]), 32'd0);
        chk("alu_op_t4", 32'(tr_op[4]), 32'd5);
        chk("alu_op_t5", 32'(tr_op[5]), 32'd5);

        // three wait cycles in T1
        mem_lat = 3;
        run_trace(I_AND);
        chk("wait_len", 32'(tr_n), 32'd9);
        chk("wait_read", 32'(cnt(B_READ)), 32'd4);
        chk("wait_mdrin", 32'(cnt(B_MDRIN)), 32'd4);
        chk("wait_pcin", 32'(cnt(B_PCIN)), 32'd1);
        chk("wait_pcin_at", 32'(first(B_PCIN)), 32'd4);
        chk("wait_irin", 32'(cnt(B_IRIN)), 32'd1);
        chk("wait_irin_at", 32'(first(B_IRIN)), 32'd5);
        mem_lat = 0;

        // MUL goes through T6
        run_trace(I_MUL);
        chk("mul_len", 32'(tr_n), 32'd7);
        chk("mul_lo_at", 32'(first(B_LOIN)), 32'd5);
        chk("mul_hi_at", 32'(first(B_HIIN)), 32'd6);
        chk("mul_no_rin", 32'(cnt(B_RIN)), 32'd0);
        chk("mul_next_t0", 32'(dut_v[B_PCOUT]), 32'd1);

        // HALT, then run low->high restarts
        run_trace(I_HALT);
        chk("halt_len", 32'(tr_n), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_hold", 32'(dut_v[B_HALTED]), 32'd1);
        end
        run = 1'b0;
        tick();
        run = 1'b1;
        chk("halt_pre_rise", 32'(dut_v[B_HALTED]), 32'd1);
        tick();
        chk("halt_restart", 32'(dut_v[B_PCOUT]), 32'd1);

        // undefined opcode
        run_trace(I_BAD);
        chk("bad_len", 32'(tr_n), 32'd4);
        chk("bad_no_yin", 32'(cnt(B_YIN)), 32'd0);
        chk("bad_flags", 32'({dut_v[B_HALTED], dut_v[B_ILL]}), 32'd3);
        next_instr = I_NOP;
        run = 1'b0;
        tick();
        tick();
        run = 1'b1;
        tick();
        chk("bad_sticky", 32'({dut_v[B_PCOUT], dut_v[B_ILL]}), 32'd3);

        // asynchronous reset while in T4
        next_instr = I_AND;
        for (int k = 0; k < 30 && !(dut_v[B_ZIN] && !dut_v[B_PCOUT]); k++) tick();
        chk("t4_reached", 32'(bus.alu_op), 32'd5);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outs", 32'(dut_v), 32'd0);
        chk("async_rst_aluop", 32'(bus.alu_op), 32'd0);
        tick();
        rst = 1'b0;

        // randomized run against the model
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            next_instr = rand_instr();
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
